// File: rtl/serializer_arb_pkg.sv
// Shared types and helpers for the serializer round-robin arbiter.
// Holds the FSM state encoding and the legal-mod check.
package serializer_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        SETTLE,
        WAIT,
        DROP
    } state_t;

    localparam int MOD_FULL = 0;
    localparam int MOD_MIN  = 3;

    // Legal: 0 (full word) or MOD_MIN..data_w bits.
    function automatic logic mod_legal(
        input logic [7:0] mod,
        input int         data_w
    );
        int m;
        m = int'(mod);
        return (m == MOD_FULL) ||
               ((m >= MOD_MIN) && (m <= data_w));
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr.
// The pointer register is owned by the instantiating module.
module rr_arbiter #(
    parameter  int REQ_CNT = 4,
    localparam int IDW     = $clog2(REQ_CNT)
) (
    input  logic [REQ_CNT-1:0] req,
    input  logic [IDW-1:0]     ptr,
    input  logic               en,
    output logic [REQ_CNT-1:0] grant,
    output logic [IDW-1:0]     grant_id
);

    logic found;

    // Scan from ptr with wrap; first hit wins.
    always_comb begin
        int idx;
        idx      = 0;
        found    = 1'b0;
        grant_id = ptr;
        for (int i = 0; i < REQ_CNT; i++) begin
            idx = (int'(ptr) + i) % REQ_CNT;
            if (!found && req[idx]) begin
                found    = 1'b1;
                grant_id = IDW'(idx);
            end
        end
        grant = '0;
        if (en && found)
            grant = REQ_CNT'(1) << grant_id;
    end

endmodule

// File: rtl/serializer_rr_arbiter.sv
// Round-robin front end sharing one serializer among requesters.
// Latches the winner, pulses ser_val_o, waits for busy to clear.
module serializer_rr_arbiter
    import serializer_arb_pkg::*;
#(
    parameter  int REQ_CNT = 4,
    parameter  int DATA_W  = 16,
    parameter  int MOD_W   = 5,
    localparam int IDW     = $clog2(REQ_CNT)
) (
    input  logic                      clk_i,
    input  logic                      srst_i,
    input  logic [REQ_CNT*DATA_W-1:0] req_data_i,
    input  logic [REQ_CNT*MOD_W-1:0]  req_mod_i,
    input  logic [REQ_CNT-1:0]        req_val_i,
    output logic [REQ_CNT-1:0]        req_ready_o,
    output logic [DATA_W-1:0]         ser_data_o,
    output logic [MOD_W-1:0]          ser_mod_o,
    output logic                      ser_val_o,
    input  logic                      ser_busy_i,
    output logic [IDW-1:0]            grant_id_o,
    output logic                      drop_o
);

    state_t           state;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   gid;
    logic [IDW-1:0]   next_ptr;
    logic [DATA_W-1:0] win_data;
    logic [MOD_W-1:0] win_mod;
    logic             arb_en;
    logic             win_legal;

    assign arb_en = (state == IDLE) && !ser_busy_i;

    rr_arbiter #(
        .REQ_CNT (REQ_CNT)
    ) u_arb (
        .req      (req_val_i),
        .ptr      (rr_ptr),
        .en       (arb_en),
        .grant    (req_ready_o),
        .grant_id (gid)
    );

    assign win_data  = req_data_i[int'(gid)*DATA_W +: DATA_W];
    assign win_mod   = req_mod_i[int'(gid)*MOD_W +: MOD_W];
    assign win_legal = mod_legal(8'(win_mod), DATA_W);
    assign next_ptr  = (int'(gid) == REQ_CNT-1) ? '0
                     : gid + 1'b1;

    // Transfer FSM with registered serializer-side outputs.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            ser_data_o <= '0;
            ser_mod_o  <= '0;
            ser_val_o  <= 1'b0;
            grant_id_o <= '0;
            drop_o     <= 1'b0;
        end else begin
            ser_val_o <= 1'b0;
            drop_o    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|req_ready_o) begin
                        rr_ptr <= next_ptr;
                        if (win_legal) begin
                            state      <= ISSUE;
                            ser_val_o  <= 1'b1;
                            ser_data_o <= win_data;
                            ser_mod_o  <= win_mod;
                            grant_id_o <= gid;
                        end else begin
                            state  <= DROP;
                            drop_o <= 1'b1;
                        end
                    end
                end
                ISSUE:  state <= SETTLE;
                SETTLE: state <= WAIT;
                WAIT: begin
                    if (!ser_busy_i)
                        state <= IDLE;
                end
                DROP:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serializer_rr_arbiter.sv
// Scoreboard bench for serializer_rr_arbiter with a serializer model.
// Directed words per requester; monitor pops expectations on outputs.
module tb_serializer_rr_arbiter;
    import serializer_arb_pkg::*;

    localparam int REQ_CNT = 4;
    localparam int DATA_W  = 16;
    localparam int MOD_W   = 5;
    localparam int IDW     = 2;

    typedef struct packed {
        logic [MOD_W-1:0]  mod;
        logic [DATA_W-1:0] data;
    } word_t;

    typedef struct packed {
        logic              drop;
        logic [IDW-1:0]    id;
        logic [DATA_W-1:0] data;
        logic [MOD_W-1:0]  mod;
        logic [IDW-1:0]    ptr;
    } exp_t;

    logic                      clk_i = 1'b0;
    logic                      srst_i;
    logic [REQ_CNT*DATA_W-1:0] req_data_i;
    logic [REQ_CNT*MOD_W-1:0]  req_mod_i;
    logic [REQ_CNT-1:0]        req_val_i;
    logic [REQ_CNT-1:0]        req_ready_o;
    logic [DATA_W-1:0]         ser_data_o;
    logic [MOD_W-1:0]          ser_mod_o;
    logic                      ser_val_o;
    logic                      ser_busy_i;
    logic [IDW-1:0]            grant_id_o;
    logic                      drop_o;

    int n_cmp  = 0;
    int n_fail = 0;
    int hs_cnt = 0;
    int sv_cnt = 0;
    int gap_en = 0;
    int last_val_cyc = -1;
    logic [DATA_W-1:0] last_bits = '0;

    word_t pend [REQ_CNT][$];
    exp_t  exp_q [$];
    exp_t  inflight = '0;

    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] got_bits;
    int                cnt;
    logic              ser_done;

    always #5 clk_i = ~clk_i;

    serializer_rr_arbiter #(
        .REQ_CNT (REQ_CNT),
        .DATA_W  (DATA_W),
        .MOD_W   (MOD_W)
    ) dut (
        .clk_i       (clk_i),
        .srst_i      (srst_i),
        .req_data_i  (req_data_i),
        .req_mod_i   (req_mod_i),
        .req_val_i   (req_val_i),
        .req_ready_o (req_ready_o),
        .ser_data_o  (ser_data_o),
        .ser_mod_o   (ser_mod_o),
        .ser_val_o   (ser_val_o),
        .ser_busy_i  (ser_busy_i),
        .grant_id_o  (grant_id_o),
        .drop_o      (drop_o)
    );

    // Serializer model: MSB first, busy for one cycle per bit.
    always @(posedge clk_i) begin
        ser_done <= 1'b0;
        if (srst_i) begin
            ser_busy_i <= 1'b0;
            cnt        <= 0;
        end else if (ser_busy_i) begin
            got_bits <= {got_bits[DATA_W-2:0], sh[DATA_W-1]};
            sh       <= sh << 1;
            cnt      <= cnt - 1;
            if (cnt == 1) begin
                ser_busy_i <= 1'b0;
                ser_done   <= 1'b1;
            end
        end else if (ser_val_o) begin
            sh         <= ser_data_o;
            got_bits   <= '0;
            cnt        <= (ser_mod_o == '0) ? DATA_W
                        : int'(ser_mod_o);
            ser_busy_i <= 1'b1;
        end
    end

    task automatic chk(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h",
                     nm, got, req);
        end
    endtask

    task automatic present(input int id);
        if (pend[id].size() > 0) begin
            req_val_i[id] = 1'b1;
            req_data_i[id*DATA_W +: DATA_W] = pend[id][0].data;
            req_mod_i[id*MOD_W +: MOD_W]    = pend[id][0].mod;
        end else begin
            req_val_i[id] = 1'b0;
        end
    endtask

    task automatic queue_word(input int id,
                              input logic [DATA_W-1:0] d,
                              input logic [MOD_W-1:0] m);
        word_t w;
        w.data = d;
        w.mod  = m;
        pend[id].push_back(w);
        if (pend[id].size() == 1)
            present(id);
    endtask

    task automatic exp_push(input logic drop, input int id,
                            input logic [DATA_W-1:0] d,
                            input logic [MOD_W-1:0] m,
                            input int ptr);
        exp_t e;
        e.drop = drop;
        e.id   = IDW'(id);
        e.data = d;
        e.mod  = m;
        e.ptr  = IDW'(ptr);
        exp_q.push_back(e);
    endtask

    task automatic check_reset();
        chk("rst_state", 32'(dut.state), 32'(IDLE));
        chk("rst_ptr", 32'(dut.rr_ptr), 32'd0);
        chk("rst_val", 32'(ser_val_o), 32'd0);
        chk("rst_drop", 32'(drop_o), 32'd0);
        chk("rst_ready", 32'(req_ready_o), 32'd0);
        chk("rst_gid", 32'(grant_id_o), 32'd0);
        chk("rst_data", 32'(ser_data_o), 32'd0);
        chk("rst_mod", 32'(ser_mod_o), 32'd0);
    endtask

    // Call right after a posedge.
    task automatic rst_pulse();
        #1 srst_i = 1'b1;
        @(posedge clk_i);
        #1 srst_i = 1'b0;
        for (int i = 0; i < REQ_CNT; i++)
            pend[i].delete();
        req_val_i = '0;
        @(negedge clk_i);
        check_reset();
    endtask

    task automatic drain(input string nm);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || ser_busy_i ||
                dut.state != IDLE || req_val_i != '0)
               && t < 600) begin
            @(negedge clk_i);
            t++;
        end
        if (t >= 600) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d left required 0",
                     nm, exp_q.size());
        end
        repeat (2) @(posedge clk_i);
        #2;
    endtask

    // Input driver: advance a requester's queue on its handshake.
    initial begin
        logic [REQ_CNT-1:0] hs_mask;
        logic               rst_edge;
        forever begin
            @(negedge clk_i);
            hs_mask = req_ready_o & req_val_i;
            @(posedge clk_i);
            rst_edge = srst_i;
            #1;
            for (int i = 0; i < REQ_CNT; i++) begin
                if (hs_mask[i] && !rst_edge &&
                    pend[i].size() > 0) begin
                    void'(pend[i].pop_front());
                    present(i);
                    hs_cnt++;
                end
            end
        end
    end

    // Monitor: latency, scoreboard, ready rules, serialized bits.
    initial begin
        int   cyc;
        int   nb;
        logic hs_last;
        exp_t e;
        cyc     = 0;
        hs_last = 1'b0;
        forever begin
            @(negedge clk_i);
            cyc++;
            if (hs_last || ser_val_o || drop_o)
                chk("latency", 32'(ser_val_o | drop_o),
                    32'(hs_last));
            hs_last = (|(req_ready_o & req_val_i)) && !srst_i;
            if (ser_val_o || drop_o) begin
                if (ser_val_o)
                    sv_cnt++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_out: got val=%0b drop=%0b required none",
                             ser_val_o, drop_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("kind_drop", 32'(drop_o), 32'(e.drop));
                    chk("ptr", 32'(dut.rr_ptr), 32'(e.ptr));
                    if (!e.drop) begin
                        chk("grant_id", 32'(grant_id_o), 32'(e.id));
                        chk("data", 32'(ser_data_o), 32'(e.data));
                        chk("mod", 32'(ser_mod_o), 32'(e.mod));
                        chk("busy_at_val", 32'(ser_busy_i), 32'd0);
                        inflight = e;
                        if (gap_en != 0 && last_val_cyc >= 0)
                            chk("gap", 32'(cyc - last_val_cyc - 1),
                                32'd5);
                        last_val_cyc = cyc;
                    end
                end
            end
            if (req_ready_o != '0) begin
                chk("ready_onehot", 32'($onehot(req_ready_o)), 32'd1);
                chk("ready_in_val",
                    32'(req_ready_o & ~req_val_i), 32'd0);
                chk("ready_idle",
                    32'(dut.state == IDLE && !ser_busy_i), 32'd1);
            end
            if (ser_done) begin
                nb = (inflight.mod == '0) ? DATA_W
                   : int'(inflight.mod);
                chk("ser_bits", 32'(got_bits),
                    32'(inflight.data >> (DATA_W - nb)));
                last_bits = got_bits;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish required finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        int h0;
        int s0;
        srst_i     = 1'b1;
        req_val_i  = '0;
        req_data_i = '0;
        req_mod_i  = '0;
        repeat (2) @(posedge clk_i);
        #1 srst_i = 1'b0;
        @(negedge clk_i);
        check_reset();
        @(posedge clk_i);
        #2;

        // 1: single full word from req0
        exp_push(1'b0, 0, 16'hA5F0, 5'd0, 1);
        queue_word(0, 16'hA5F0, 5'd0);
        drain("t1");
        chk("t1_bits", 32'(last_bits), 32'h0000A5F0);

        // 2: all four, two rounds, pointer from 0
        @(posedge clk_i);
        rst_pulse();
        @(posedge clk_i);
        #2;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < REQ_CNT; i++)
                exp_push(1'b0, i,
                         {4'(i), 4'(r), 8'h5A},
                         5'd4, (i + 1) % REQ_CNT);
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < REQ_CNT; i++)
                queue_word(i, {4'(i), 4'(r), 8'h5A}, 5'd4);
        drain("t2");

        // 3: req2 holds valid, req1 joins mid-transfer
        exp_push(1'b0, 2, 16'h1234, 5'd8, 3);
        exp_push(1'b0, 1, 16'hBEEF, 5'd0, 2);
        exp_push(1'b0, 2, 16'hC3C3, 5'd5, 3);
        queue_word(2, 16'h1234, 5'd8);
        queue_word(2, 16'hC3C3, 5'd5);
        repeat (3) @(posedge clk_i);
        #2;
        queue_word(1, 16'hBEEF, 5'd0);
        drain("t3");

        // 4: illegal mods 1, 17, 2 from req1
        h0 = hs_cnt;
        s0 = sv_cnt;
        exp_push(1'b1, 1, '0, '0, 2);
        exp_push(1'b1, 1, '0, '0, 2);
        exp_push(1'b1, 1, '0, '0, 2);
        queue_word(1, 16'h1111, 5'd1);
        queue_word(1, 16'h2222, 5'd17);
        queue_word(1, 16'h3333, 5'd2);
        drain("t4");
        chk("t4_ready_pulses", 32'(hs_cnt - h0), 32'd3);
        chk("t4_no_val", 32'(sv_cnt - s0), 32'd0);

        // 5a: reset while waiting on busy
        exp_push(1'b0, 0, 16'h0F0F, 5'd0, 1);
        queue_word(0, 16'h0F0F, 5'd0);
        t = 0;
        while (dut.state != WAIT && t < 50) begin
            @(negedge clk_i);
            t++;
        end
        chk("t5_reach_wait", 32'(dut.state == WAIT), 32'd1);
        repeat (2) @(posedge clk_i);
        @(posedge clk_i);
        rst_pulse();
        s0 = sv_cnt;
        repeat (30) @(posedge clk_i);
        #2;
        chk("t5_wait_no_val", 32'(sv_cnt - s0), 32'd0);

        // 5b: reset during ISSUE, mod 16 boundary
        exp_push(1'b0, 1, 16'h5555, 5'd16, 2);
        queue_word(1, 16'h5555, 5'd16);
        t = 0;
        @(negedge clk_i);
        while ((req_ready_o & req_val_i) == '0 && t < 50) begin
            @(negedge clk_i);
            t++;
        end
        @(posedge clk_i);
        #1;
        chk("t5_in_issue", 32'(dut.state), 32'(ISSUE));
        rst_pulse();
        s0 = sv_cnt;
        repeat (30) @(posedge clk_i);
        #2;
        chk("t5_issue_no_val", 32'(sv_cnt - s0), 32'd0);
        chk("t5_no_busy", 32'(ser_busy_i), 32'd0);

        // 6: back-to-back mod 3 words from req0
        gap_en       = 1;
        last_val_cyc = -1;
        exp_push(1'b0, 0, 16'hE000, 5'd3, 1);
        exp_push(1'b0, 0, 16'h2000, 5'd3, 1);
        exp_push(1'b0, 0, 16'hA000, 5'd3, 1);
        queue_word(0, 16'hE000, 5'd3);
        queue_word(0, 16'h2000, 5'd3);
        queue_word(0, 16'hA000, 5'd3);
        drain("t6");
        gap_en = 0;
        chk("t6_last_bits", 32'(last_bits), 32'd5);

        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
